// File: rtl/clock_divider_bank.sv
// clock_divider_bank: multi-channel programmable clock divider / tick generator.
// Each channel counts 0..div and then wraps. On each wrap it either toggles a
// square-wave level or emits a one-cycle tick. New divisors are staged and only
// take effect at the channel's next terminal count, so a period is never cut short.
module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 50_000_000,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CHANNELS-1:0] en,
    input  logic [CHANNELS-1:0] mode,
    input  logic                sync_clr,
    input  logic                div_wr,
    input  logic [CH_W-1:0]     div_ch,
    input  logic [CNT_W-1:0]    div_val,
    output logic [CHANNELS-1:0] ck_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pend
);

    logic [CNT_W-1:0]    r_cnt   [CHANNELS];
    logic [CNT_W-1:0]    r_div   [CHANNELS];
    logic [CNT_W-1:0]    r_stage [CHANNELS];
    logic [CHANNELS-1:0] r_ck;
    logic [CHANNELS-1:0] r_tick;
    logic [CHANNELS-1:0] r_pend;

    logic [CHANNELS-1:0] w_wr_hit;
    logic [CHANNELS-1:0] w_term;

    // Decode the write target and each channel's terminal condition.
    // A div_ch value beyond the last channel matches no channel and is dropped.
    always_comb begin
        w_wr_hit = '0;
        w_term   = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_wr_hit[i] = div_wr && (div_ch == CH_W'(i));
            w_term[i]   = (r_cnt[i] >= r_div[i]);
        end
    end

    // Per-channel counter, output level, tick and divisor staging.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_cnt[i]   <= '0;
                r_div[i]   <= CNT_W'(DEFAULT_DIV);
                r_stage[i] <= '0;
            end
            r_ck   <= '0;
            r_tick <= '0;
            r_pend <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (sync_clr) begin
                    r_cnt[i]  <= '0;
                    r_ck[i]   <= 1'b0;
                    r_tick[i] <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_stage[i];
                        r_pend[i] <= 1'b0;
                    end
                end else if (!en[i]) begin
                    // Idle channel: freeze count and level, flush any staged divisor.
                    r_tick[i] <= 1'b0;
                    if (r_pend[i]) begin
                        r_div[i]  <= r_stage[i];
                        r_pend[i] <= 1'b0;
                    end
                end else begin
                    r_tick[i] <= w_term[i];
                    r_cnt[i]  <= w_term[i] ? '0 : r_cnt[i] + CNT_W'(1);
                    if (mode[i]) begin
                        r_ck[i] <= 1'b0;
                    end else if (w_term[i]) begin
                        r_ck[i] <= ~r_ck[i];
                    end
                    if (w_term[i] && r_pend[i]) begin
                        r_div[i]  <= r_stage[i];
                        r_pend[i] <= 1'b0;
                    end
                end
                // A write lands after any apply above, so a write coinciding
                // with a terminal stays staged for the following terminal.
                if (w_wr_hit[i]) begin
                    r_stage[i] <= div_val;
                    r_pend[i]  <= 1'b1;
                end
            end
        end
    end

    assign ck_out = r_ck;
    assign tick   = r_tick;
    assign pend   = r_pend;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Testbench for clock_divider_bank: directed vector table, directed corner
// sequences and a randomized run, all compared against a bench-side model.
module tb_clock_divider_bank;

    localparam int NCH  = 4;
    localparam int CW   = 3;
    localparam int DDIV = 12;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NCH-1:0]  en;
    logic [NCH-1:0]  mode;
    logic            sync_clr;
    logic            div_wr;
    logic [CW-1:0]   div_ch;
    logic [31:0]     div_val;
    logic [NCH-1:0]  ck_out;
    logic [NCH-1:0]  tick;
    logic [NCH-1:0]  pend;

    int n_checks = 0;
    int n_fail   = 0;

    clock_divider_bank #(
        .CHANNELS    (NCH),
        .CNT_W       (32),
        .DEFAULT_DIV (DDIV),
        .CH_W        (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .en       (en),
        .mode     (mode),
        .sync_clr (sync_clr),
        .div_wr   (div_wr),
        .div_ch   (div_ch),
        .div_val  (div_val),
        .ck_out   (ck_out),
        .tick     (tick),
        .pend     (pend)
    );

    always #5 CLK = ~CLK;

    // Reference model: each channel described by its position within the
    // current period, its active period length and an optional queued divisor.
    int unsigned m_pos   [NCH];
    int unsigned m_div   [NCH];
    int unsigned m_queue [NCH];
    bit          m_has_q [NCH];
    bit          m_level [NCH];
    bit          m_tick  [NCH];

    function automatic void model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit wrote;
            wrote = div_wr && (int'(div_ch) < NCH) && (int'(div_ch) == c);
            if (RST) begin
                m_pos[c] = 0; m_div[c] = DDIV; m_queue[c] = 0;
                m_has_q[c] = 0; m_level[c] = 0; m_tick[c] = 0;
                continue;
            end
            if (sync_clr) begin
                m_pos[c] = 0; m_level[c] = 0; m_tick[c] = 0;
                if (m_has_q[c]) begin m_div[c] = m_queue[c]; m_has_q[c] = 0; end
            end else if (!en[c]) begin
                m_tick[c] = 0;
                if (m_has_q[c]) begin m_div[c] = m_queue[c]; m_has_q[c] = 0; end
            end else begin
                bit wrap;
                wrap = (m_pos[c] >= m_div[c]);
                m_tick[c] = wrap;
                if (wrap) begin
                    m_pos[c] = 0;
                    if (m_has_q[c]) begin m_div[c] = m_queue[c]; m_has_q[c] = 0; end
                end else begin
                    m_pos[c] = m_pos[c] + 1;
                end
                if (mode[c]) m_level[c] = 0;
                else if (wrap) m_level[c] = !m_level[c];
            end
            if (wrote) begin m_queue[c] = div_val; m_has_q[c] = 1; end
        end
    endfunction

    function automatic logic [NCH-1:0] pack(input bit v [NCH]);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = v[c];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ck_out"}, 32'(ck_out), 32'(pack(m_level)));
        check({tag, ".tick"},   32'(tick),   32'(pack(m_tick)));
        check({tag, ".pend"},   32'(pend),   32'(pack(m_has_q)));
    endtask

    task automatic idle_inputs();
        sync_clr = 0; div_wr = 0; div_ch = '0; div_val = '0;
    endtask

    typedef struct {
        logic [NCH-1:0] en;
        logic [NCH-1:0] mode;
        logic           wr;
        logic [CW-1:0]  ch;
        logic [31:0]    val;
        logic [NCH-1:0] ck;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] pd;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic [3:0] e, input logic [3:0] m, input logic w,
                                input logic [2:0] ch, input logic [31:0] v,
                                input logic [3:0] ck, input logic [3:0] tk, input logic [3:0] pd);
        vec_t r;
        r.en = e; r.mode = m; r.wr = w; r.ch = ch; r.val = v;
        r.ck = ck; r.tk = tk; r.pd = pd;
        return r;
    endfunction

    initial begin
        // Ch0 gets div=3 (applied while idle), runs an 8-cycle square wave,
        // ignores a write to channel 5, then switches to div=1 at cnt=1.
        // Ch1 becomes a div=0 pulse channel.
        tbl[0]  = mk(4'b0000, 4'b0000, 1, 3'd0, 3, 4'b0000, 4'b0000, 4'b0001);
        tbl[1]  = mk(4'b0000, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[2]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[3]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[4]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[5]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[6]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0000, 4'b0000);
        tbl[7]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0000, 4'b0000);
        tbl[8]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0000, 4'b0000);
        tbl[9]  = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[10] = mk(4'b0001, 4'b0000, 1, 3'd5, 7, 4'b0000, 4'b0000, 4'b0000);
        tbl[11] = mk(4'b0001, 4'b0000, 1, 3'd0, 1, 4'b0000, 4'b0000, 4'b0001);
        tbl[12] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0001);
        tbl[13] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[14] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0000, 4'b0000);
        tbl[15] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[16] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0000, 4'b0000, 4'b0000);
        tbl[17] = mk(4'b0001, 4'b0000, 0, 3'd0, 0, 4'b0001, 4'b0001, 4'b0000);
        tbl[18] = mk(4'b0001, 4'b0010, 1, 3'd1, 0, 4'b0001, 4'b0000, 4'b0010);
        tbl[19] = mk(4'b0001, 4'b0010, 0, 3'd0, 0, 4'b0000, 4'b0001, 4'b0000);
        tbl[20] = mk(4'b0011, 4'b0010, 0, 3'd0, 0, 4'b0000, 4'b0010, 4'b0000);
        tbl[21] = mk(4'b0011, 4'b0010, 0, 3'd0, 0, 4'b0001, 4'b0011, 4'b0000);
        tbl[22] = mk(4'b0011, 4'b0010, 0, 3'd0, 0, 4'b0001, 4'b0010, 4'b0000);

        // Reset
        RST = 1; en = '0; mode = '0; idle_inputs();
        cycle();
        cycle();
        check("reset.ck_out", 32'(ck_out), 32'h0);
        check("reset.tick",   32'(tick),   32'h0);
        check("reset.pend",   32'(pend),   32'h0);
        RST = 0;

        // Vector table
        foreach (tbl[k]) begin
            en = tbl[k].en; mode = tbl[k].mode;
            div_wr = tbl[k].wr; div_ch = tbl[k].ch; div_val = tbl[k].val;
            cycle();
            check($sformatf("tbl%0d.ck_out", k), 32'(ck_out), 32'(tbl[k].ck));
            check($sformatf("tbl%0d.tick", k),   32'(tick),   32'(tbl[k].tk));
            check($sformatf("tbl%0d.pend", k),   32'(pend),   32'(tbl[k].pd));
        end
        idle_inputs();

        // Enable freeze: ch2 div=5, drop en at cnt=2 for 10 cycles, then resume.
        en = 4'b0000; mode = 4'b0000;
        div_wr = 1; div_ch = 3'd2; div_val = 5;
        cycle(); check_model("frz.wr");
        idle_inputs();
        cycle(); check_model("frz.apply");
        en = 4'b0100;
        begin
            int guard = 0;
            while (m_pos[2] != 2 && guard < 50) begin
                cycle(); check_model("frz.run"); guard++;
            end
            if (m_pos[2] != 2) begin
                n_checks++; n_fail++;
                $display("FAIL frz.reach: cnt never reached 2 within bound");
            end
        end
        begin
            logic held;
            held = m_level[2];
            en = 4'b0000;
            for (int k = 0; k < 10; k++) begin
                cycle();
                check("frz.ck_hold", 32'(ck_out[2]), 32'(held));
                check("frz.tick0",   32'(tick[2]),   32'h0);
            end
        end
        en = 4'b0100;
        for (int k = 0; k < 12; k++) begin cycle(); check_model("frz.resume"); end

        // sync_clr with channels at divs 1..4, then RST mid-count.
        en = 4'b0000;
        for (int c = 0; c < NCH; c++) begin
            div_wr = 1; div_ch = CW'(c); div_val = c + 1;
            cycle(); check_model("sc.wr");
        end
        idle_inputs();
        cycle(); check_model("sc.apply");
        en = 4'b1111; mode = 4'b0000;
        for (int k = 0; k < 7; k++) begin cycle(); check_model("sc.run"); end
        sync_clr = 1;
        cycle();
        sync_clr = 0;
        check("sc.ck_out", 32'(ck_out), 32'h0);
        check("sc.tick",   32'(tick),   32'h0);
        check_model("sc.post");
        for (int k = 0; k < 5; k++) begin cycle(); check_model("sc.rerun"); end
        div_wr = 1; div_ch = 3'd3; div_val = 9;
        cycle(); check_model("rst.prewr");
        idle_inputs();
        RST = 1;
        cycle();
        RST = 0;
        check("rst.ck_out", 32'(ck_out), 32'h0);
        check("rst.tick",   32'(tick),   32'h0);
        check("rst.pend",   32'(pend),   32'h0);

        // After reset the default divisor gives the first tick on the 13th edge.
        en = 4'b0001;
        for (int k = 0; k < DDIV; k++) begin
            cycle();
            check("dflt.no_tick", 32'(tick[0]), 32'h0);
        end
        cycle();
        check("dflt.tick", 32'(tick[0]), 32'h1);
        check("dflt.ck",   32'(ck_out[0]), 32'h1);

        // Randomized run against the model.
        for (int k = 0; k < 3000; k++) begin
            RST      = ($urandom_range(0, 199) == 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            div_wr   = ($urandom_range(0, 5) == 0);
            div_ch   = CW'($urandom_range(0, 7));
            div_val  = $urandom_range(0, 6);
            if ($urandom_range(0, 3) == 0) en = NCH'($urandom);
            if ($urandom_range(0, 19) == 0) mode = NCH'($urandom);
            cycle();
            check_model("rand");
        end
        RST = 0; idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
